// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns, special codes and the
// BCD->segment encoder table used by both the display driver and the reader.
package seg7_pkg;

   // Segment bit order: bit0=top .. bit5=upper-left, bit6=middle
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h27;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [3:0] CODE_BLANK = 4'hF;
   localparam logic [3:0] CODE_ERR   = 4'hE;

   function automatic logic [6:0] seg7_encode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_if.sv
// Frame output port of the 7-segment reader: valid/ready handshake carrying
// the decoded digit codes and per-digit error flags.
interface seg7_if #(
   parameter int NDIG = 4
) ();
   logic              out_valid;
   logic              out_ready;
   logic [4*NDIG-1:0] out_data;
   logic [NDIG-1:0]   out_err;

   modport master (output out_valid, output out_data, output out_err, input  out_ready);
   modport slave  (input  out_valid, input  out_data, input  out_err, output out_ready);
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern decoder: maps a 7-bit pattern back to its
// 4-bit code; blank gives CODE_BLANK, anything unrecognised gives CODE_ERR.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] code,
   output logic       err
);

   always_comb begin
      err  = 1'b0;
      code = CODE_ERR;
      case (seg)
         SEG_0:     code = 4'd0;
         SEG_1:     code = 4'd1;
         SEG_2:     code = 4'd2;
         SEG_3:     code = 4'd3;
         SEG_4:     code = 4'd4;
         SEG_5:     code = 4'd5;
         SEG_6:     code = 4'd6;
         SEG_7:     code = 4'd7;
         SEG_8:     code = 4'd8;
         SEG_9:     code = 4'd9;
         SEG_BLANK: code = CODE_BLANK;
         default: begin
            code = CODE_ERR;
            err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg7_reader.sv
// Multiplexed 7-segment bus reader: glitch-filters the sampled bus, decodes
// each strobed digit and presents complete frames on a valid/ready port.
module seg7_reader
   import seg7_pkg::*;
#(
   parameter int NDIG          = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [6:0]      seg_in,
   input  logic [NDIG-1:0] dig_sel,
   seg7_if.master          frm,
   output logic            overrun
);

   localparam int               CNT_W      = 4;
   localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   logic [6:0]        seg_p0, seg_p1;
   logic [NDIG-1:0]   sel_p0, sel_p1;
   logic [CNT_W-1:0]  cnt_p1, cnt_nxt;
   logic              committed_p1;
   logic              same, commit, complete, accept, load;
   logic [3:0]        dec_code;
   logic              dec_err;
   logic [NDIG-1:0]   mask, mask_nxt;
   logic [4*NDIG-1:0] cap_data, cap_data_nxt, out_data_q;
   logic [NDIG-1:0]   cap_err, cap_err_nxt, out_err_q;
   logic              out_valid_q;

   seg7_pattern_decode u_decode (
      .seg  (seg_p0),
      .code (dec_code),
      .err  (dec_err)
   );

   // Compare stage: current registered pair against the previous one
   assign same    = (seg_p0 == seg_p1) && (sel_p0 == sel_p1);
   assign cnt_nxt = same ? sat_inc(cnt_p1) : '0;
   // A changed pair starts a fresh run, so the committed flag is ignored then
   assign commit  = $onehot(sel_p0) && (cnt_nxt == CNT_COMMIT) && (!same || !committed_p1);

   assign mask_nxt = mask | sel_p0;
   assign complete = commit && (&mask_nxt);
   assign accept   = out_valid_q && frm.out_ready;
   assign load     = complete && (!out_valid_q || frm.out_ready);

   always_comb begin
      cap_data_nxt = cap_data;
      cap_err_nxt  = cap_err;
      for (int i = 0; i < NDIG; i++) begin
         if (sel_p0[i]) begin
            cap_data_nxt[4*i +: 4] = dec_code;
            cap_err_nxt[i]         = dec_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_p0       <= '0;
         sel_p0       <= '0;
         seg_p1       <= '0;
         sel_p1       <= '0;
         cnt_p1       <= '0;
         committed_p1 <= 1'b0;
         mask         <= '0;
         cap_data     <= '0;
         cap_err      <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_err_q    <= '0;
         overrun      <= 1'b0;
      end else begin
         // Input register stage
         seg_p0 <= seg_in;
         sel_p0 <= dig_sel;
         // History/filter stage
         seg_p1 <= seg_p0;
         sel_p1 <= sel_p0;
         cnt_p1 <= cnt_nxt;
         if (!same)
            committed_p1 <= 1'b0;
         if (commit) begin
            committed_p1 <= 1'b1;
            cap_data     <= cap_data_nxt;
            cap_err      <= cap_err_nxt;
            mask         <= complete ? '0 : mask_nxt;
         end
         // Frame output stage
         if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= cap_data_nxt;
            out_err_q   <= cap_err_nxt;
         end else if (accept) begin
            out_valid_q <= 1'b0;
         end
         if (complete && !load)
            overrun <= 1'b1;
      end
   end

   assign frm.out_valid = out_valid_q;
   assign frm.out_data  = out_data_q;
   assign frm.out_err   = out_err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: run-length/frame model compared every cycle, plus
// directed frames with literal expected codes.
module tb_seg7_reader;

   localparam int NDIG = 4;
   localparam int S    = 3;
   localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h27, 7'h7F, 7'h6F};

   logic            clk;
   logic            rst_n;
   logic [6:0]      seg_in;
   logic [NDIG-1:0] dig_sel;
   logic            overrun;

   int checks   = 0;
   int failures = 0;

   seg7_if #(.NDIG(NDIG)) frm ();

   seg7_reader #(.NDIG(NDIG), .STABLE_CYCLES(S)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .seg_in  (seg_in),
      .dig_sel (dig_sel),
      .frm     (frm),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [6:0]        m_lseg, m_pseg;
   logic [NDIG-1:0]   m_lsel, m_psel, m_mask, m_e, m_err;
   logic [3:0]        m_code [NDIG];
   logic [4*NDIG-1:0] m_data;
   logic              m_pend, m_valid, m_ovr;
   int                m_run;

   function automatic logic [4:0] m_dec(input logic [6:0] s);
      if (s == 7'h00) return {1'b0, 4'hF};
      for (int i = 0; i < 10; i++)
         if (SEG_TAB[i] == s) return {1'b0, 4'(i)};
      return {1'b1, 4'hE};
   endfunction

   task automatic m_reset();
      m_lseg = '0; m_lsel = '0; m_run = 1; m_pend = 1'b0;
      m_pseg = '0; m_psel = '0; m_mask = '0; m_e = '0;
      m_valid = 1'b0; m_data = '0; m_err = '0; m_ovr = 1'b0;
      for (int i = 0; i < NDIG; i++) m_code[i] = '0;
   endtask

   task automatic m_step();
      logic acc, done;
      logic [4:0] d;
      acc  = m_valid && frm.out_ready;
      done = 1'b0;
      if (m_pend) begin
         d = m_dec(m_pseg);
         for (int i = 0; i < NDIG; i++)
            if (m_psel[i]) begin
               m_code[i] = d[3:0];
               m_e[i]    = d[4];
               m_mask[i] = 1'b1;
            end
         if (&m_mask) begin
            done   = 1'b1;
            m_mask = '0;
         end
      end
      if (done && (!m_valid || acc)) begin
         m_valid = 1'b1;
         for (int i = 0; i < NDIG; i++) m_data[4*i +: 4] = m_code[i];
         m_err = m_e;
      end else begin
         if (done) m_ovr = 1'b1;
         if (acc)  m_valid = 1'b0;
      end
      // Sample taken on this edge; a run commits on the edge after its S-th sample
      if (seg_in == m_lseg && dig_sel == m_lsel) begin
         if (m_run < 1000) m_run++;
      end else begin
         m_run  = 1;
         m_lseg = seg_in;
         m_lsel = dig_sel;
      end
      m_pend = (m_run == S) && $onehot(dig_sel);
      m_pseg = seg_in;
      m_psel = dig_sel;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else        m_step();
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_valid", 32'(frm.out_valid), 32'(m_valid));
         chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
         if (m_valid) begin
            chk("cyc_data", 32'(frm.out_data), 32'(m_data));
            chk("cyc_err", 32'(frm.out_err), 32'(m_err));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [6:0] s, input logic [NDIG-1:0] d, input int n);
      seg_in  = s;
      dig_sel = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
      drive(s0, 4'b0001, S);
      drive(s1, 4'b0010, S);
      drive(s2, 4'b0100, S);
      drive(s3, 4'b1000, S);
   endtask

   task automatic accept_frame(input string nm);
      frm.out_ready = 1'b1;
      @(negedge clk);
      frm.out_ready = 1'b0;
      chk(nm, 32'(frm.out_valid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; seg_in = '0; dig_sel = '0; frm.out_ready = 1'b0;

      // Reset with random activity on the inputs
      repeat (5) begin
         @(negedge clk);
         seg_in        = 7'($urandom);
         dig_sel       = 4'($urandom);
         frm.out_ready = 1'($urandom);
      end
      @(negedge clk);
      chk("rst_valid", 32'(frm.out_valid), 32'd0);
      chk("rst_data", 32'(frm.out_data), 32'd0);
      chk("rst_err", 32'(frm.out_err), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      seg_in = '0; dig_sel = '0; frm.out_ready = 1'b0;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("idle_valid", 32'(frm.out_valid), 32'd0);

      // Basic frame 1,2,3,4
      frame4(7'h06, 7'h5B, 7'h4F, 7'h66);
      chk("basic_before_commit", 32'(frm.out_valid), 32'd0);
      drive(7'h00, 4'b0000, 1);
      chk("basic_valid", 32'(frm.out_valid), 32'd1);
      chk("basic_data", 32'(frm.out_data), 32'h4321);
      chk("basic_err", 32'(frm.out_err), 32'h0);
      accept_frame("basic_accept");

      // Glitchy digit2, then a multi-hot strobe that must not commit
      drive(7'h7F, 4'b0100, 2);
      drive(7'h6F, 4'b0100, 2);
      drive(7'h7F, 4'b0100, 2);
      drive(7'h6F, 4'b0100, 3);
      drive(7'h3F, 4'b1000, 3);
      drive(7'h06, 4'b0011, 10);
      drive(7'h00, 4'b0000, 1);
      chk("multihot_no_frame", 32'(frm.out_valid), 32'd0);
      drive(7'h5B, 4'b0001, 3);
      drive(7'h4F, 4'b0010, 3);
      drive(7'h00, 4'b0000, 1);
      chk("glitch_valid", 32'(frm.out_valid), 32'd1);
      chk("glitch_data", 32'(frm.out_data), 32'h0932);
      accept_frame("glitch_accept");

      // Blank and invalid patterns
      frame4(7'h00, 7'h49, 7'h7D, 7'h27);
      drive(7'h00, 4'b0000, 1);
      chk("inval_data", 32'(frm.out_data), 32'h76EF);
      chk("inval_err", 32'(frm.out_err), 32'h2);
      accept_frame("inval_accept");

      // Back-pressure: second frame dropped, third loads during acceptance
      frame4(7'h6D, 7'h7F, 7'h3F, 7'h06);
      drive(7'h00, 4'b0000, 1);
      chk("bp_a_data", 32'(frm.out_data), 32'h1085);
      chk("bp_a_overrun", 32'(overrun), 32'd0);
      frame4(7'h66, 7'h66, 7'h66, 7'h66);
      drive(7'h00, 4'b0000, 1);
      chk("bp_held_valid", 32'(frm.out_valid), 32'd1);
      chk("bp_held_data", 32'(frm.out_data), 32'h1085);
      chk("bp_overrun", 32'(overrun), 32'd1);
      frame4(7'h4F, 7'h4F, 7'h27, 7'h7F);
      frm.out_ready = 1'b1;
      drive(7'h00, 4'b0000, 1);
      frm.out_ready = 1'b0;
      chk("bp_c_valid", 32'(frm.out_valid), 32'd1);
      chk("bp_c_data", 32'(frm.out_data), 32'h8733);
      chk("bp_c_overrun", 32'(overrun), 32'd1);
      accept_frame("bp_c_accept");

      // Reset in the middle of a frame
      drive(7'h06, 4'b0001, 3);
      drive(7'h5B, 4'b0010, 3);
      drive(7'h00, 4'b0000, 1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_overrun", 32'(overrun), 32'd0);
      chk("mid_rst_data", 32'(frm.out_data), 32'd0);
      rst_n = 1'b1;
      drive(7'h00, 4'b0000, 2);
      drive(7'h7D, 4'b0100, 3);
      drive(7'h6F, 4'b1000, 3);
      drive(7'h00, 4'b0000, 1);
      chk("mid_rst_partial", 32'(frm.out_valid), 32'd0);
      drive(7'h66, 4'b0001, 3);
      drive(7'h6D, 4'b0010, 3);
      drive(7'h00, 4'b0000, 1);
      chk("mid_rst_valid", 32'(frm.out_valid), 32'd1);
      chk("mid_rst_frame", 32'(frm.out_data), 32'h9654);
      accept_frame("mid_rst_accept");

      drive(7'h00, 4'b0000, 3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
